// File: rtl/csnc_dec_feeder.sv
// Share collector and sequencer feeding the k=3, n=5 CSNC erasure decoder.
//
// Collects the first three distinct roles of a generation, drops duplicate,
// late (already completed generation) and out-of-range shares, then streams
// the three buffered shares in ascending role order with tlast on the third.
//
// Optional feature: define CSNC_FEED_TIMEOUT_EN to abandon a generation that
// sees no accepted share for TIMEOUT cycles while collecting.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_*               incoming shares (tdata, role, gen, tvalid/tready)
//   m_axis_*               shares to decoder (tdata, role, tvalid/tready, tlast)
//   stat_drop              one-cycle pulse per dropped share
//   stat_timeout           one-cycle pulse when a generation is abandoned
//   gen_done               one-cycle pulse on the final output handshake
module csnc_dec_feeder #(
  parameter int unsigned LOUT    = 12,
  parameter int unsigned GW      = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [LOUT-1:0] s_axis_tdata,
  input  logic [2:0]      s_axis_role,
  input  logic [GW-1:0]   s_axis_gen,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic [LOUT-1:0] m_axis_tdata,
  output logic [2:0]      m_axis_role,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic            stat_drop,
  output logic            stat_timeout,
  output logic            gen_done
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StCollect, StIssue} state_e;

  state_e          state_q;
  logic [LOUT-1:0] buf_q [5];
  logic [4:0]      have_q;
  logic [1:0]      cnt_q;
  logic [1:0]      out_cnt_q;
  logic [GW-1:0]   open_gen_q;
  logic [GW-1:0]   last_gen_q;
  logic            last_vld_q;
  logic            s_tready_q;
  logic            m_tvalid_q;
  logic [LOUT-1:0] m_tdata_q;
  logic [2:0]      m_role_q;
  logic            m_tlast_q;
  logic            stat_drop_q;
  logic            stat_timeout_q;
  logic            gen_done_q;

`ifdef CSNC_FEED_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT);
  logic [IW-1:0] idle_q;
`endif

  function automatic logic [2:0] lowest(input logic [4:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic            s_hs, m_hs, role_ok, gen_match, s_drop, s_accept;
  logic [4:0]      role_bit, mask_full, rem;
  logic [2:0]      first, nxt;
  logic [LOUT-1:0] first_data;

  always_comb begin
    s_hs      = s_axis_tvalid & s_tready_q;
    m_hs      = m_tvalid_q & m_axis_tready;
    role_ok   = (s_axis_role <= 3'd4);
    role_bit  = 5'b00001 << s_axis_role;
    gen_match = (s_axis_gen == open_gen_q);
    // First output is chosen at the edge that accepts the third share, so the
    // incoming share may itself be the lowest role and bypass the buffer.
    mask_full  = have_q | role_bit;
    first      = lowest(mask_full);
    first_data = (first == s_axis_role) ? s_axis_tdata : buf_q[first];
    rem        = have_q & ~(5'b00001 << m_role_q);
    nxt        = lowest(rem);

    s_drop   = 1'b0;
    s_accept = 1'b0;
    if (s_hs) begin
      if (!role_ok) begin
        s_drop = 1'b1;
      end else if (state_q == StIdle) begin
        if (last_vld_q && (s_axis_gen == last_gen_q)) s_drop = 1'b1;
        else                                          s_accept = 1'b1;
      end else if (state_q == StCollect) begin
        if (gen_match && ((have_q & role_bit) != 5'd0)) s_drop = 1'b1;
        else                                              s_accept = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      for (int i = 0; i < 5; i++) buf_q[i] <= '0;
      have_q         <= '0;
      cnt_q          <= '0;
      out_cnt_q      <= '0;
      open_gen_q     <= '0;
      last_gen_q     <= '0;
      last_vld_q     <= 1'b0;
      s_tready_q     <= 1'b0;
      m_tvalid_q     <= 1'b0;
      m_tdata_q      <= '0;
      m_role_q       <= '0;
      m_tlast_q      <= 1'b0;
      stat_drop_q    <= 1'b0;
      stat_timeout_q <= 1'b0;
      gen_done_q     <= 1'b0;
`ifdef CSNC_FEED_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      stat_drop_q    <= s_drop;
      stat_timeout_q <= 1'b0;
      gen_done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          s_tready_q <= 1'b1;
          if (s_accept) begin
            buf_q[s_axis_role] <= s_axis_tdata;
            have_q             <= role_bit;
            cnt_q              <= 2'd1;
            open_gen_q         <= s_axis_gen;
            state_q            <= StCollect;
`ifdef CSNC_FEED_TIMEOUT_EN
            idle_q             <= '0;
`endif
          end
        end
        StCollect: begin
          if (s_accept) begin
            buf_q[s_axis_role] <= s_axis_tdata;
`ifdef CSNC_FEED_TIMEOUT_EN
            idle_q             <= '0;
`endif
            if (!gen_match) begin
              // New generation displaces the open one.
              stat_timeout_q <= 1'b1;
              have_q         <= role_bit;
              cnt_q          <= 2'd1;
              open_gen_q     <= s_axis_gen;
            end else begin
              have_q <= mask_full;
              if (cnt_q == 2'd2) begin
                state_q    <= StIssue;
                s_tready_q <= 1'b0;
                m_tvalid_q <= 1'b1;
                m_role_q   <= first;
                m_tdata_q  <= first_data;
                m_tlast_q  <= 1'b0;
                out_cnt_q  <= 2'd0;
              end else begin
                cnt_q <= cnt_q + 2'd1;
              end
            end
          end
`ifdef CSNC_FEED_TIMEOUT_EN
          else if (idle_q == IW'(TIMEOUT - 1)) begin
            stat_timeout_q <= 1'b1;
            have_q         <= '0;
            cnt_q          <= '0;
            state_q        <= StIdle;
          end else begin
            idle_q <= idle_q + IW'(1);
          end
`endif
        end
        StIssue: begin
          if (m_hs) begin
            have_q <= rem;
            if (out_cnt_q == 2'd2) begin
              m_tvalid_q <= 1'b0;
              m_tlast_q  <= 1'b0;
              gen_done_q <= 1'b1;
              last_gen_q <= open_gen_q;
              last_vld_q <= 1'b1;
              cnt_q      <= '0;
              s_tready_q <= 1'b1;
              state_q    <= StIdle;
            end else begin
              m_role_q  <= nxt;
              m_tdata_q <= buf_q[nxt];
              m_tlast_q <= (out_cnt_q == 2'd1);
              out_cnt_q <= out_cnt_q + 2'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_role   = m_role_q;
  assign m_axis_tlast  = m_tlast_q;
  assign stat_drop     = stat_drop_q;
  assign stat_timeout  = stat_timeout_q;
  assign gen_done      = gen_done_q;

endmodule

// File: doc/csnc_dec_feeder.md
# csnc_dec_feeder

Share collector and sequencer for the k=3, n=5 CSNC erasure decoder. It accepts 12-bit coded shares from the receive path, each tagged with a role (0–2 = d0..d2, 3–4 = p0/p1) and a generation ID. It keeps the first three distinct roles of a generation and drops duplicates, late shares and out-of-range roles. It then streams exactly three shares, in ascending role order with tlast on the third, into the decoder's AXI-Stream slave port.

## Interface
Parameters:
- LOUT, 12, share width in bits (11-bit payload + parity MSB)
- GW, 8, generation ID width
- TIMEOUT, 1024, idle cycles allowed inside an open generation before it is abandoned (≥2)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  LOUT  incoming share
- s_axis_role  in  3  share role, 0..4 valid
- s_axis_gen  in  GW  generation ID
- s_axis_tvalid  in  1  share valid
- s_axis_tready  out  1  feeder can accept a share
- m_axis_tdata  out  LOUT  share to decoder
- m_axis_role  out  3  role to decoder
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  decoder ready
- m_axis_tlast  out  1  third share of the generation
- stat_drop  out  1  one-cycle pulse per dropped share
- stat_timeout  out  1  one-cycle pulse when a generation is abandoned
- gen_done  out  1  one-cycle pulse on the final output handshake

## Operation
- Storage: 5-entry share buffer indexed by role, 5-bit `have` mask, 2-bit count, open-gen register, last-done-gen register with valid flag.
- IDLE
  - s_axis_tready=1.
  - A share with role>4 is dropped.
  - A share whose gen equals last-done-gen (while that flag is valid) is dropped.
  - Any other share is stored: open-gen ← gen, mask bit set, count=1, go to COLLECT.
- COLLECT
  - s_axis_tready=1.
  - Same gen and new role: store it and increment count. When count reaches 3, go to ISSUE.
  - Same gen and duplicate role: drop.
  - Role>4: drop.
  - Different gen: abandon the current generation (stat_timeout pulse, mask cleared), then treat the share as the first share of a new generation (count=1, stay in COLLECT).
- ISSUE
  - s_axis_tready=0.
  - Presents the lowest set role in the mask on m_axis_*; clears that bit on each output handshake.
  - m_axis_tlast=1 on the third share.
  - On the third handshake: gen_done pulse, last-done-gen ← open-gen, last-done flag set, go to IDLE.
- Every drop raises stat_drop for exactly one cycle. A drop is still a handshake: tvalid & tready, so the share is consumed.
- All role and gen comparisons are exact and unsigned; the gen ID is allowed to wrap.

## Timing
- Reset values (asserted asynchronously, released synchronously): s_axis_tready=0, then 1 from the first cycle after reset release. m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_role=0, stat_drop=0, stat_timeout=0, gen_done=0. State=IDLE, mask=0, last-done flag=0.
- All outputs are registered.
- Latency: if the third distinct share is accepted at edge T, m_axis_tvalid is high in the cycle after T. With m_axis_tready held high, the three outputs take three consecutive cycles.
- s_axis_tready falls in the cycle after the third share is accepted. It rises in the cycle after the third output handshake.
- m_axis_tdata, m_axis_role and m_axis_tlast are held stable while tvalid=1 and tready=0.
- stat_* and gen_done pulse in the cycle after the triggering handshake.
- Reset mid-ISSUE discards the buffered generation with no partial tlast.

## Configuration
- CSNC_FEED_TIMEOUT_EN defined:
  - An idle counter runs in COLLECT. It resets on every accepted (non-dropped) share.
  - When it reaches TIMEOUT-1, the generation is abandoned: stat_timeout pulse, mask cleared, go to IDLE.
- CSNC_FEED_TIMEOUT_EN undefined:
  - No counter.
  - COLLECT is left only by count reaching 3, a gen change, or reset.
  - stat_timeout is driven only by gen-change abandonment.

## Test plan
- Gen 0x01, shares roles 4,1,3, m_tready=1 → outputs roles 1,3,4 on three consecutive cycles, tlast on role 4, gen_done once, data identical to inputs.
- Gen 0x02, roles 0,0,2,4 → second role-0 share dropped (stat_drop=1 once), outputs roles 0,2,4.
- After gen 0x02 completes, send gen 0x02 role 1 → dropped with stat_drop. Then gen 0x03 roles 0,1,2 → outputs 0,1,2.
- Gen 0x05 roles 0,3, then gen 0x06 roles 1,2,4 → stat_timeout pulse, outputs roles 1,2,4 only.
- m_tready toggling 1,0,0,1,0,1 during ISSUE → each output held stable until its handshake; s_tready=0 throughout ISSUE.
- With CSNC_FEED_TIMEOUT_EN and TIMEOUT=16: one share, then 16 idle cycles → stat_timeout, return to IDLE. Next gen with 3 shares completes normally.
